uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit frame sequencer (start, data, optional parity, stop)
//
// Serialises one byte per frame onto tx, LSB first, timed by a 16x oversampling tick.
// Optional parity bit is compiled in with the macro UART_TX_PARITY_EN.
//
// Parameters:
//   DBIT       data bits per frame (5..8)
//   SB_TICK    stop-bit length in s_tick pulses (16 = 1 stop bit, 32 = 2 stop bits)
//   PARITY_ODD 0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   s_tick        16x baud tick, one-cycle pulse
//   tx_data[7:0]  byte to send, bits [DBIT-1:0] used
//   tx_valid      requester has a byte ready
//   tx_ready      sequencer is idle and accepts a byte
//   tx            serial line, idle high, driven from a flop
//   tx_done_tick  one-cycle pulse on the last stop tick of a frame

module uart_tx_sequencer #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done_tick
);

    // Elaboration-time parameter sanity checks.
    if (DBIT < 5 || DBIT > 8) begin : g_bad_dbit
        $error("uart_tx_sequencer: DBIT must be 5..8");
    end
    if (SB_TICK < 1 || SB_TICK > 32) begin : g_bad_sb_tick
        $error("uart_tx_sequencer: SB_TICK must be 1..32");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_sequencer: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    localparam logic [4:0] S_BIT_LAST  = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    state_t            state_reg, state_next;
    logic [4:0]        s_reg, s_next;
    logic [2:0]        n_reg, n_next;
    logic [DBIT-1:0]   b_reg, b_next;
    logic              tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        n_next      = n_reg;
        b_next      = b_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                // tx_ready is exactly (state == IDLE), so tx_valid here is a transfer.
                // A coincident s_tick is deliberately ignored.
                if (tx_valid) begin
                    state_next  = START;
                    s_next      = '0;
                    n_next      = '0;
                    b_next      = tx_data[DBIT-1:0];
`ifdef UART_TX_PARITY_EN
                    parity_next = (^tx_data[DBIT-1:0]) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP_LAST) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line value is computed from the next state so tx flips on the
        // same edge as the state / shift register.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        tx_ready     = (state_reg == IDLE);
        tx_done_tick = (state_reg == STOP) && s_tick && (s_reg == S_STOP_LAST);
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - directed table-driven bench for uart_tx_sequencer
module tb_uart_tx_sequencer;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    int         sel;

    logic [2:0] valid_w, rdy_w, tx_w, done_w;
    logic       tx_o, rdy_o, done_o;

    assign valid_w[0] = tx_valid && (sel == 0);
    assign valid_w[1] = tx_valid && (sel == 1);
    assign valid_w[2] = tx_valid && (sel == 2);
    assign tx_o   = tx_w[sel[1:0]];
    assign rdy_o  = rdy_w[sel[1:0]];
    assign done_o = done_w[sel[1:0]];

    uart_tx_sequencer u_dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data),
        .tx_valid(valid_w[0]), .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_done_tick(done_w[0])
    );

    uart_tx_sequencer #(.DBIT(7), .SB_TICK(32)) u_d7 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data),
        .tx_valid(valid_w[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_done_tick(done_w[1])
    );

    uart_tx_sequencer #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data),
        .tx_valid(valid_w[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_done_tick(done_w[2])
    );

    always #5 clk = ~clk;

    // s_tick on every 4th cycle, changed just after the rising edge.
    int ph = 0;
    always @(posedge clk) begin
        #1;
        ph = (ph + 1) % 4;
        s_tick = (ph == 0);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cur_vec = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0h expected %0h", cur_vec, name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         sel;
        bit         hold;
        bit         align;
        int         abort_at;
        logic       exp_par;
        int         exp_waits;
    } vec_t;

    vec_t vecs[9];

    task automatic run_frame(input logic [7:0] d, input logic [7:0] mid_d, input bit hold,
                             input bit align, input int abort_at, input logic exp_par,
                             input int exp_waits);
        int   dbit, sb, total, c, waits, done_at, k;
        logic exp_bit;
        bit   got;
        dbit    = (sel == 1) ? 7 : 8;
        sb      = (sel == 1) ? 32 : 16;
        total   = 16 * (1 + dbit + PAR_EN) + sb;
        waits   = 0;
        got     = 0;
        c       = 0;
        done_at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waits++;
            if (rdy_o && (!align || s_tick)) begin
                got = 1;
                break;
            end
        end
        check("ready_wait", 32'(got), 32'd1);
        check("idle_tx", 32'(tx_o), 32'd1);
        if (exp_waits >= 0) check("idle_gap", waits, exp_waits);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = hold;
        tx_data  = mid_d;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("start_tx", 32'(tx_o), 32'd0);
                check("busy_ready", 32'(rdy_o), 32'd0);
            end
            if (abort_at >= 0 && c == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_tx", 32'(tx_o), 32'd1);
                check("abort_ready", 32'(rdy_o), 32'd1);
                check("abort_done", 32'(done_o), 32'd0);
                @(posedge clk);
                #1;
                check("reset_hold_done", 32'(done_o), 32'd0);
                reset = 1'b0;
                break;
            end
            if (s_tick) begin
                if (c % 16 == 8) begin
                    k = c / 16;
                    if (k == 0)                          exp_bit = 1'b0;
                    else if (k <= dbit)                  exp_bit = d[k-1];
                    else if (PAR_EN == 1 && k == dbit+1) exp_bit = exp_par;
                    else                                 exp_bit = 1'b1;
                    check($sformatf("bit%0d", k), 32'(tx_o), 32'(exp_bit));
                end
                c++;
                if (done_o) begin
                    done_at = c;
                    break;
                end
            end else if (done_o) begin
                done_at = -2;
                break;
            end
        end
        if (abort_at < 0) check("done_at_tick", done_at, total);
    endtask

    initial begin
        // data, sel, hold, align, abort_at, exp_par (even unless sel 2), exp_waits
        vecs[0] = '{8'hA5, 0, 1'b0, 1'b0, -1, 1'b0, -1};
        vecs[1] = '{8'h3C, 0, 1'b1, 1'b0, -1, 1'b0, -1};
        vecs[2] = '{8'hC3, 0, 1'b0, 1'b0, -1, 1'b0,  1};
        vecs[3] = '{8'hFF, 0, 1'b0, 1'b0, 72, 1'b0, -1};
        vecs[4] = '{8'h55, 0, 1'b0, 1'b0, -1, 1'b0, -1};
        vecs[5] = '{8'h07, 0, 1'b0, 1'b1, -1, 1'b1, -1};
        vecs[6] = '{8'h7F, 1, 1'b0, 1'b0, -1, 1'b1, -1};
        vecs[7] = '{8'hA5, 2, 1'b0, 1'b0, -1, 1'b1, -1};
        vecs[8] = '{8'h07, 2, 1'b0, 1'b0, -1, 1'b0, -1};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel      = 0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_ready", 32'(rdy_o), 32'd1);
        check("reset_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            logic [7:0] mid;
            cur_vec = i;
            sel = vecs[i].sel;
            mid = vecs[i].hold ? vecs[i+1].data : ~vecs[i].data;
            run_frame(vecs[i].data, mid, vecs[i].hold, vecs[i].align, vecs[i].abort_at,
                      vecs[i].exp_par, vecs[i].exp_waits);
        end

        cur_vec = 9;
        @(negedge clk);
        check("final_ready", 32'(rdy_o), 32'd1);
        check("final_tx", 32'(tx_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
